// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU.
//   - function-select codes for s
//   - FSM state type
//   - xy_sel(): maps s and one A/B nibble pair to the {X,Y} adder operand nibbles
package alu_seq_pkg;

   localparam logic [3:0] S_A           = 4'd0;   // X=A,     Y=0
   localparam logic [3:0] S_AOB         = 4'd1;   // X=A|B,   Y=0
   localparam logic [3:0] S_AONB        = 4'd2;   // X=A|~B,  Y=0
   localparam logic [3:0] S_M1          = 4'd3;   // X=0,     Y=1s
   localparam logic [3:0] S_A_P_ANB     = 4'd4;   // X=A,     Y=A&~B
   localparam logic [3:0] S_AOB_P_ANB   = 4'd5;   // X=A|B,   Y=A&~B
   localparam logic [3:0] S_A_M_B       = 4'd6;   // X=A,     Y=~B
   localparam logic [3:0] S_AB_M1       = 4'd7;   // X=A&B,   Y=1s
   localparam logic [3:0] S_A_P_AB      = 4'd8;   // X=A,     Y=A&B
   localparam logic [3:0] S_A_P_B       = 4'd9;   // X=A,     Y=B
   localparam logic [3:0] S_AONB_P_AB   = 4'd10;  // X=A|~B,  Y=A&B
   localparam logic [3:0] S_AB_M1_ALT   = 4'd11;  // X=A&B,   Y=1s
   localparam logic [3:0] S_A_P_A       = 4'd12;  // X=A,     Y=A
   localparam logic [3:0] S_AOB_P_A     = 4'd13;  // X=A|B,   Y=A
   localparam logic [3:0] S_AONB_P_A    = 4'd14;  // X=A|~B,  Y=A
   localparam logic [3:0] S_A_M1        = 4'd15;  // X=A,     Y=1s

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns {X, Y}. Bitwise only, so it works nibble by nibble.
   function automatic logic [7:0] xy_sel(input logic [3:0] s,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
      logic [3:0] x;
      logic [3:0] y;
      x = a;
      y = 4'h0;
      case (s)
         S_A:         begin x = a;      y = 4'h0;   end
         S_AOB:       begin x = a | b;  y = 4'h0;   end
         S_AONB:      begin x = a | ~b; y = 4'h0;   end
         S_M1:        begin x = 4'h0;   y = 4'hF;   end
         S_A_P_ANB:   begin x = a;      y = a & ~b; end
         S_AOB_P_ANB: begin x = a | b;  y = a & ~b; end
         S_A_M_B:     begin x = a;      y = ~b;     end
         S_AB_M1:     begin x = a & b;  y = 4'hF;   end
         S_A_P_AB:    begin x = a;      y = a & b;  end
         S_A_P_B:     begin x = a;      y = b;      end
         S_AONB_P_AB: begin x = a | ~b; y = a & b;  end
         S_AB_M1_ALT: begin x = a & b;  y = 4'hF;   end
         S_A_P_A:     begin x = a;      y = a;      end
         S_AOB_P_A:   begin x = a | b;  y = a;      end
         S_AONB_P_A:  begin x = a | ~b; y = a;      end
         default:     begin x = a;      y = 4'hF;   end  // S_A_M1
      endcase
      return {x, y};
   endfunction

endpackage

// File: rtl/alu_seq_slice_alu_slice4.sv
// alu_slice4: combinational 4-bit slice, carry-lookahead adder plus per-bit logic unit.
// Ports:
//   x, y   in  4  adder operands (already mapped from A/B by xy_sel)
//   a, b   in  4  raw operand nibbles for the logic unit
//   s      in  4  function select (logic mode truth-table bits)
//   m      in  1  1 = logic result, 0 = sum
//   cin    in  1  active-high carry into bit 0
//   f      out 4  result nibble
//   cout   out 1  active-high carry out of bit 3 (meaningful in arithmetic mode only)
module alu_slice4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       cin,
   output logic [3:0] f,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;
   logic [3:0] sum;
   logic [3:0] lgc;

   assign g = x & y;
   assign p = x ^ y;

   // Flat lookahead equations; every carry depends only on g, p and cin.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum = p ^ c[3:0];

   // s acts as a truth table indexed by {a,b}: s0 for 01, s1 for 00, s2 for 10, s3 for 11.
   assign lgc = (~a &  b & {4{~s[0]}})
              | (~a & ~b & {4{~s[1]}})
              | ( a & ~b & {4{ s[2]}})
              | ( a &  b & {4{ s[3]}});

   assign f    = m ? lgc : sum;
   assign cout = c[4];

endmodule

// File: rtl/alu_seq_slice.sv
// alu_seq_slice: multi-cycle WIDTH-bit ALU that reuses one alu_slice4, one nibble per
// cycle from LSB to MSB, with the inter-nibble carry held in a register.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, s, m, cin_n captured on acceptance)
//   out_valid/out_ready result handshake
//   f                   WIDTH-bit result
//   cout_n              active-low carry out of the MSB nibble, 1 in logic mode
//   zero                f == 0
//
// state | meaning
// IDLE  | waiting for an operand bundle, in_ready high
// RUN   | one nibble per cycle, idx_q selects the nibble
// DONE  | result held, out_valid high until out_ready
module alu_seq_slice
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             cin_n,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f,
   output logic             cout_n,
   output logic             zero
);

   localparam int NSLICE = WIDTH / 4;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

   state_t           state_q;
   logic [IDXW-1:0]  idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       s_q;
   logic             m_q;
   logic [WIDTH-1:0] f_q;
   logic             cout_n_q;
   logic             out_valid_q;

   logic [3:0]       a_nib;
   logic [3:0]       b_nib;
   logic [7:0]       xy;
   logic [3:0]       slice_f;
   logic             slice_cout;

   assign a_nib = a_q[{idx_q, 2'b00} +: 4];
   assign b_nib = b_q[{idx_q, 2'b00} +: 4];
   assign xy    = xy_sel(s_q, a_nib, b_nib);

   alu_slice4 u_slice (
      .x    (xy[7:4]),
      .y    (xy[3:0]),
      .a    (a_nib),
      .b    (b_nib),
      .s    (s_q),
      .m    (m_q),
      .cin  (carry_q),
      .f    (slice_f),
      .cout (slice_cout)
   );

   // Gated by rst so in_ready is already low during the reset cycle itself.
   assign in_ready  = (state_q == IDLE) && !rst;
   assign out_valid = out_valid_q;
   assign f         = f_q;
   assign cout_n    = cout_n_q;
   assign zero      = (f_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         s_q         <= 4'h0;
         m_q         <= 1'b0;
         f_q         <= '0;
         cout_n_q    <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  s_q     <= s;
                  m_q     <= m;
                  carry_q <= ~cin_n;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               f_q[{idx_q, 2'b00} +: 4] <= slice_f;
               carry_q                  <= slice_cout;
               if (idx_q == LAST_IDX) begin
                  cout_n_q    <= m_q ? 1'b1 : ~slice_cout;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_slice.sv
// Self-checking bench for alu_seq_slice (WIDTH=16): directed literal cases plus
// randomized operations compared every cycle against a whole-word reference model.
module tb_alu_seq_slice;

   localparam int W      = 16;
   localparam int NSLICE = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [3:0]   s;
   logic         m;
   logic         cin_n;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] f;
   logic         cout_n;
   logic         zero;

   int checks = 0;
   int errors = 0;

   alu_seq_slice #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .s         (s),
      .m         (m),
      .cin_n     (cin_n),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .f         (f),
      .cout_n    (cout_n),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Whole-word reference: plain integer arithmetic over W bits.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [3:0] ms, input logic mm, input logic mcn,
                                 output logic [W-1:0] mf, output logic mco_n);
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W:0]   sum;
      logic [W-1:0] ones;
      ones = '1;
      if (mm) begin
         mf    = (~ma & mb & {W{~ms[0]}}) | (~ma & ~mb & {W{~ms[1]}})
               | (ma & ~mb & {W{ms[2]}})  | (ma & mb & {W{ms[3]}});
         mco_n = 1'b1;
      end else begin
         case (ms)
            4'd0:  begin x = ma;        y = '0;        end
            4'd1:  begin x = ma | mb;   y = '0;        end
            4'd2:  begin x = ma | ~mb;  y = '0;        end
            4'd3:  begin x = '0;        y = ones;      end
            4'd4:  begin x = ma;        y = ma & ~mb;  end
            4'd5:  begin x = ma | mb;   y = ma & ~mb;  end
            4'd6:  begin x = ma;        y = ~mb;       end
            4'd7:  begin x = ma & mb;   y = ones;      end
            4'd8:  begin x = ma;        y = ma & mb;   end
            4'd9:  begin x = ma;        y = mb;        end
            4'd10: begin x = ma | ~mb;  y = ma & mb;   end
            4'd11: begin x = ma & mb;   y = ones;      end
            4'd12: begin x = ma;        y = ma;        end
            4'd13: begin x = ma | mb;   y = ma;        end
            4'd14: begin x = ma | ~mb;  y = ma;        end
            default: begin x = ma;      y = ones;      end
         endcase
         sum   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~mcn};
         mf    = sum[W-1:0];
         mco_n = ~sum[W];
      end
   endfunction

   // Transaction-level model state: one op outstanding at most.
   int           cyc     = 0;
   bit           pending = 1'b0;
   bit           fresh   = 1'b1;
   int           acc_cyc = 0;
   logic [W-1:0] exp_f   = '0;
   logic         exp_co  = 1'b1;

   always @(posedge clk) begin
      if (rst) begin
         pending = 1'b0;
         fresh   = 1'b1;
      end else if (pending) begin
         if (cyc >= acc_cyc + NSLICE && out_ready)
            pending = 1'b0;
      end else if (in_valid) begin
         pending = 1'b1;
         fresh   = 1'b0;
         acc_cyc = cyc + 1;
         model(a, b, s, m, cin_n, exp_f, exp_co);
      end
      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         logic ov;
         ov = pending && (cyc >= acc_cyc + NSLICE);
         chk("in_ready", in_ready, (!pending && !rst));
         chk("out_valid", out_valid, ov);
         if (ov) begin
            chk("f", f, exp_f);
            chk("cout_n", cout_n, exp_co);
            chk("zero", zero, (exp_f == '0));
         end else if (fresh) begin
            chk("f_rst", f, 0);
            chk("cout_n_rst", cout_n, 1);
            chk("zero_rst", zero, 1);
         end
      end
   end

   task automatic randomize_inputs();
      a     = W'($urandom);
      b     = W'($urandom);
      s     = 4'($urandom);
      m     = 1'($urandom);
      cin_n = 1'($urandom);
   endtask

   // Launches one op; returns after the acceptance edge (+2).
   task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] ts,
                         input logic tm, input logic tcn, output int t0);
      int n;
      a = ta; b = tb_; s = ts; m = tm; cin_n = tcn;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", n);
      end
      @(posedge clk); #2;
      t0 = cyc;
      in_valid = 1'b0;
      randomize_inputs();
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [3:0] ts,
                         input logic tm, input logic tcn, input int hold,
                         input bit lit, input logic [W-1:0] lf, input logic lco);
      int t0;
      int n;
      launch(ta, tb_, ts, tm, tcn, t0);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #2;
         n++;
         randomize_inputs();
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL done_timeout: out_valid stayed 0 for %0d cycles", n);
      end
      if (lit) begin
         chk("lit_latency", cyc - t0, NSLICE);
         chk("lit_f", f, lf);
         chk("lit_cout_n", cout_n, lco);
         chk("lit_zero", zero, (lf == '0));
         chk("lit_model_f", exp_f, lf);
      end
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom);
         randomize_inputs();
         @(posedge clk); #2;
      end
      if (lit) chk("lit_f_held", f, lf);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #2;
      out_ready = 1'b0;
      chk("out_valid_drop", out_valid, 0);
   endtask

   initial begin
      int t0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; s = 4'h0; m = 1'b0; cin_n = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_f", f, 0);
      chk("rst_cout_n", cout_n, 1);
      chk("rst_zero", zero, 1);
      chk("idle_in_ready", in_ready, 1);

      run_op(16'h1234, 16'h0FFF, 4'd9, 1'b0, 1'b1, 0, 1'b1, 16'h2233, 1'b1);
      run_op(16'hFFFF, 16'h0001, 4'd9, 1'b0, 1'b1, 0, 1'b1, 16'h0000, 1'b0);
      run_op(16'h0005, 16'h0003, 4'd6, 1'b0, 1'b0, 0, 1'b1, 16'h0002, 1'b0);
      run_op(16'h0005, 16'h0003, 4'd6, 1'b0, 1'b1, 0, 1'b1, 16'h0001, 1'b0);
      run_op(16'hF0F0, 16'hFF00, 4'b0110, 1'b1, 1'b0, 0, 1'b1, 16'h0FF0, 1'b1);
      // Backpressure: 10 cycles held with inputs churning.
      run_op(16'h1234, 16'h0FFF, 4'd9, 1'b0, 1'b1, 10, 1'b1, 16'h2233, 1'b1);

      // Abort in the second RUN cycle.
      launch(16'hABCD, 16'h1111, 4'd9, 1'b0, 1'b1, t0);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_f", f, 0);
      chk("abort_in_ready", in_ready, 1);
      run_op(16'h00FF, 16'h0001, 4'd9, 1'b0, 1'b1, 2, 1'b1, 16'h0100, 1'b1);

      for (int k = 0; k < 60; k++) begin
         run_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), 1'b0, '0, 1'b0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #2;
      end

      repeat (3) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq_slice.md
# alu_seq_slice

Parametrised multi-cycle ALU that runs the team's 4-bit arithmetic/logic function set over WIDTH-bit operands. It reuses one 4-bit carry-lookahead slice, processing one nibble per cycle from least significant to most significant and holding the inter-slice carry in a register. It sits between an operand source and a result consumer, with valid/ready handshakes on both sides. It replaces the single-cycle 4-bit combinational ALU wherever a wider datapath is needed at small area.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived; not overridable.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle.
- a, b  in  WIDTH  operands.
- s  in  4  function select.
- m  in  1  1 = logic mode, 0 = arithmetic mode.
- cin_n  in  1  active-low carry-in (1 = no carry).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  result.
- cout_n  out  1  active-low carry-out of the MSB slice; 1 in logic mode.
- zero  out  1  f == 0.

## Operation
- Logic mode, per bit: f = (~a&b&~s0) | (~a&~b&~s1) | (a&~b&s2) | (a&b&s3).
- Arithmetic mode: f = X + Y + (~cin_n), truncated to WIDTH. cout_n = ~carry out of bit WIDTH-1.
- X,Y by s:
  - 0: A, 0.
  - 1: A|B, 0.
  - 2: A|~B, 0.
  - 3: 0, all-ones.
  - 4: A, A&~B.
  - 5: A|B, A&~B.
  - 6: A, ~B.
  - 7: A&B, all-ones.
  - 8: A, A&B.
  - 9: A, B.
  - 10: A|~B, A&B.
  - 11: A&B, all-ones.
  - 12: A, A.
  - 13: A|B, A.
  - 14: A|~B, A.
  - 15: A, all-ones.
- X and Y are bitwise functions, so each nibble is formed from the matching nibbles of the latched a and b.
- Inputs are captured on acceptance (in_valid & in_ready). Later changes on a, b, s, m and cin_n have no effect on the operation in flight.
- State machine:
  - IDLE: in_ready=1. On acceptance, latch the operands, set the slice index to 0 and the carry register to ~cin_n, then go to RUN.
  - RUN: in_ready=0. Each cycle computes slice k, writes f[4k+3:4k] and updates the carry register. After slice NSLICE-1, go to DONE.
  - DONE: out_valid=1, outputs held stable. When out_ready=1, go to IDLE.
- Logic mode also spends NSLICE cycles in RUN, so latency is uniform across modes. The carry register is ignored in logic mode, and cout_n is forced to 1.
- zero is computed from the full result register and is valid whenever out_valid=1.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1. out_valid=0, f=0, cout_n=1, zero=1, state IDLE.
- Acceptance in cycle t gives out_valid=1 from cycle t+NSLICE+1.
- out_valid stays high and f/cout_n/zero stay stable until the cycle in which out_ready=1. out_valid drops the following cycle.
- in_ready=1 only in IDLE. There is no bypass: the next acceptance can happen no earlier than the cycle after the handshake completes, so throughput is one op per NSLICE+2 cycles.
- rst asserted in any state, including mid-RUN, aborts the operation. All outputs return to reset values on the next edge and the partial result is discarded.
- WIDTH=4 gives a single RUN cycle.

## Structure
- Package alu_seq_pkg holds:
  - the 4-bit function-code constants for s;
  - the state enum (IDLE, RUN, DONE);
  - a function returning {X,Y} nibbles for a given s.
- One sub-module, alu_slice4: a combinational 4-bit CLA plus per-bit logic unit.
  - Inputs: X and Y nibbles, A and B nibbles, s, m, carry-in.
  - Outputs: result nibble, carry-out.
  - Instantiated exactly once.
- The top level holds the FSM, the slice counter, the operand/result registers and the carry register.

## Test plan
- WIDTH=16, m=0, s=9, cin_n=1, a=0x1234, b=0x0FFF → f=0x2233, cout_n=1, zero=0; out_valid first high 5 cycles after acceptance.
- m=0, s=9, cin_n=1, a=0xFFFF, b=0x0001 → f=0x0000, cout_n=0, zero=1 (carry ripples through all four slices).
- m=0, s=6, cin_n=0, a=0x0005, b=0x0003 → f=0x0002, cout_n=0; with cin_n=1 → f=0x0001.
- m=1, s=4'b0110, a=0xF0F0, b=0xFF00 → f=0x0FF0 (XOR), cout_n=1.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and f stay stable and in_ready stays 0 throughout; change the operand inputs meanwhile → no effect on f.
- Assert rst in the second RUN cycle → next cycle out_valid=0, f=0, state IDLE; a fresh op then completes correctly.
